// File: rtl/subtraction_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package subtraction_pkg;

  // Default operand/result width in bits (legal range 2..32).
  localparam int SUB_WIDTH_DEFAULT = 8;

  // Controller states. Encoding is fixed so that decoded outputs stay stable
  // across tools and netlists.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between a controller (master) and the
// bit-serial subtractor (slave).
interface serial_subtractor_if
  import subtraction_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
);

  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
  logic             o_ovf;

  // Controller side: issues requests and operands, observes status/results.
  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_diff, o_borrow, o_ovf
  );

  // Subtractor side: accepts requests, produces status/results.
  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_diff, o_borrow, o_ovf
  );

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: computes a - b - borrow_in.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  // Difference bit is the parity of the three inputs; a borrow is needed when
  // b exceeds a, or when they are equal and a borrow is already pending.
  assign o_diff   = i_a ^ i_b ^ i_borrow;
  assign o_borrow = (~i_a & i_b) | (~(i_a ^ i_b) & i_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow. Results are published only
// on the completion edge; start/busy/done handshake towards the controller.
module serial_subtractor
  import subtraction_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  serial_subtractor_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  // Operand shift registers; bit 0 feeds the subtractor cell each cycle.
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  // Result bits produced so far; the final bit is merged in on the last edge,
  // so only WIDTH-1 bits ever need storing.
  logic [WIDTH-2:0] sh_res;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  // Operand sign bits, kept for the overflow decision at completion.
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             ovf_q;

  logic             bit_d;
  logic             bit_bout;
  logic             accept;
  logic             last_bit;

  full_subtractor u_full_subtractor (
    .i_a      (sh_a[0]),
    .i_b      (sh_b[0]),
    .i_borrow (borrow_q),
    .o_diff   (bit_d),
    .o_borrow (bit_bout)
  );

  // A request is only honoured when no operation is in flight.
  assign accept   = bus.i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST_BIT);
  assign res_nxt  = {bit_d, sh_res};

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts one cycle and can chain straight into SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_BIT) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = bus.i_start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state, so they are glitch-free
  // and mutually exclusive.
  always_comb begin
    bus.o_busy = (state == ST_SHIFT);
    bus.o_done = (state == ST_DONE);
  end

  // Serial datapath: load on accept, shift one bit per SHIFT cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_res   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else if (accept) begin
      sh_a     <= bus.i_a;
      sh_b     <= bus.i_b;
      a_msb    <= bus.i_a[WIDTH-1];
      b_msb    <= bus.i_b[WIDTH-1];
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == ST_SHIFT) begin
      sh_a     <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b     <= {1'b0, sh_b[WIDTH-1:1]};
      sh_res   <= res_nxt[WIDTH-1:1];
      borrow_q <= bit_bout;
      // Counter parks at the last index instead of wrapping.
      if (!last_bit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result registers: updated only on the completion edge so that partial
  // results are never visible. Overflow occurs when the operand signs differ
  // and the result sign disagrees with the minuend.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (last_bit) begin
      diff_q       <= res_nxt;
      borrow_out_q <= bit_bout;
      ovf_q        <= (a_msb != b_msb) && (bit_d != a_msb);
    end
  end

  assign bus.o_diff   = diff_q;
  assign bus.o_borrow = borrow_out_q;
  assign bus.o_ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed scenarios plus randomised operands at
// two widths, compared against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int acc8  = 0;

  serial_subtractor_if #(.WIDTH(8))  b8 ();
  serial_subtractor_if #(.WIDTH(13)) b13 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (b13)
  );

  logic fa, fb, fbin, fd, fbo;
  full_subtractor u_fs (
    .i_a      (fa),
    .i_b      (fb),
    .i_borrow (fbin),
    .o_diff   (fd),
    .o_borrow (fbo)
  );

  // Reference: plain integer arithmetic on the operands at width w.
  task automatic ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic bo, output logic ov);
    longint full, half, ua, ub, sa, sb, r;
    full = longint'(1) << w;
    half = full >> 1;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    r  = sa - sb;
    ov = (r < -half) || (r >= half);
    bo = (ua < ub);
    d  = 32'((ua - ub) & (full - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    b8.i_start = 1'b1;
    b8.i_a = a;
    b8.i_b = b;
    tick();
    b8.i_start = 1'b0;
    acc8 = cyc;
  endtask

  // Returns latency in clocks from the accepting edge (-1 if no done seen).
  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (b8.o_busy) busy_cnt++;
      if (b8.o_done) begin
        lat = cyc - acc8;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.i_start = 1'b0; b8.i_a = '0; b8.i_b = '0;
    b13.i_start = 1'b0; b13.i_a = '0; b13.i_b = '0;
    #12;
    total++; if (b8.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", b8.o_busy); end
    total++; if (b8.o_done !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", b8.o_done); end
    total++; if (b8.o_diff !== 8'h00) begin bad++; $display("FAIL reset_diff8 got=%h exp=00", b8.o_diff); end
    total++; if (b8.o_borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow8 got=%b exp=0", b8.o_borrow); end
    total++; if (b8.o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf8 got=%b exp=0", b8.o_ovf); end
    total++; if (b13.o_busy !== 1'b0 || b13.o_done !== 1'b0) begin bad++; $display("FAIL reset_stat13 got=%b%b exp=00", b13.o_busy, b13.o_done); end
    total++; if (b13.o_diff !== 13'h0) begin bad++; $display("FAIL reset_diff13 got=%h exp=0", b13.o_diff); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_subtractor();
    for (int v = 0; v < 8; v++) begin
      int r;
      fa = v[2]; fb = v[1]; fbin = v[0];
      #1;
      r = int'(fa) - int'(fb) - int'(fbin);
      total++; if (fd !== r[0]) begin bad++; $display("FAIL fs_diff v=%0d got=%b exp=%b", v, fd, r[0]); end
      total++; if (fbo !== (r < 0)) begin bad++; $display("FAIL fs_borrow v=%0d got=%b exp=%b", v, fbo, (r < 0)); end
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    start8(8'h5A, 8'h23);
    wait_done8(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    total++; if (b8.o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_with_done got=%b exp=0", b8.o_busy); end
    total++; if (b8.o_diff !== 8'h37) begin bad++; $display("FAIL basic_diff got=%h exp=37", b8.o_diff); end
    total++; if (b8.o_borrow !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b exp=0", b8.o_borrow); end
    total++; if (b8.o_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", b8.o_ovf); end
    tick();
    total++; if (b8.o_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", b8.o_done); end
    total++; if (b8.o_diff !== 8'h37) begin bad++; $display("FAIL basic_diff_held got=%h exp=37", b8.o_diff); end
  endtask

  task automatic test_borrow();
    int lat, bc;
    start8(8'h10, 8'h20);
    wait_done8(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL borrow1_latency got=%0d exp=8", lat); end
    total++; if ({b8.o_diff, b8.o_borrow, b8.o_ovf} !== {8'hF0, 1'b1, 1'b0}) begin bad++;
      $display("FAIL borrow1_result got=%h/%b/%b exp=f0/1/0", b8.o_diff, b8.o_borrow, b8.o_ovf); end
    start8(8'h00, 8'hFF);
    wait_done8(lat, bc);
    total++; if ({b8.o_diff, b8.o_borrow, b8.o_ovf} !== {8'h01, 1'b1, 1'b0}) begin bad++;
      $display("FAIL borrow2_result got=%h/%b/%b exp=01/1/0", b8.o_diff, b8.o_borrow, b8.o_ovf); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    start8(8'h80, 8'h01);
    wait_done8(lat, bc);
    total++; if ({b8.o_diff, b8.o_borrow, b8.o_ovf} !== {8'h7F, 1'b0, 1'b1}) begin bad++;
      $display("FAIL ovf1_result got=%h/%b/%b exp=7f/0/1", b8.o_diff, b8.o_borrow, b8.o_ovf); end
    start8(8'h7F, 8'hFF);
    wait_done8(lat, bc);
    total++; if ({b8.o_diff, b8.o_borrow, b8.o_ovf} !== {8'h80, 1'b1, 1'b1}) begin bad++;
      $display("FAIL ovf2_result got=%h/%b/%b exp=80/1/1", b8.o_diff, b8.o_borrow, b8.o_ovf); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start8(8'h5A, 8'h23);
    repeat (3) tick();
    // Request during SHIFT must be ignored.
    b8.i_start = 1'b1; b8.i_a = 8'hFF; b8.i_b = 8'h00;
    tick();
    b8.i_start = 1'b0;
    total++; if (b8.o_diff === 8'hFF) begin bad++; $display("FAIL ignore_no_partial got=%h exp=not ff", b8.o_diff); end
    wait_done8(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
    total++; if (b8.o_diff !== 8'h37) begin bad++; $display("FAIL ignore_diff got=%h exp=37", b8.o_diff); end
    // Start held during the DONE cycle chains straight into a new operation.
    start8(8'h09, 8'h04);
    total++; if (b8.o_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", b8.o_busy); end
    wait_done8(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    total++; if (b8.o_diff !== 8'h05) begin bad++; $display("FAIL b2b_diff got=%h exp=05", b8.o_diff); end
  endtask

  task automatic test_async_reset();
    int lat, bc, seen;
    start8(8'h33, 8'h11);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if ({b8.o_busy, b8.o_done} !== 2'b00) begin bad++; $display("FAIL areset_status got=%b%b exp=00", b8.o_busy, b8.o_done); end
    total++; if ({b8.o_diff, b8.o_borrow, b8.o_ovf} !== 10'd0) begin bad++;
      $display("FAIL areset_outputs got=%h/%b/%b exp=00/0/0", b8.o_diff, b8.o_borrow, b8.o_ovf); end
    repeat (2) tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (b8.o_done || b8.o_busy) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL areset_no_done got=%0d exp=0", seen); end
    start8(8'h33, 8'h11);
    wait_done8(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL areset_rerun_latency got=%0d exp=8", lat); end
    total++; if (b8.o_diff !== 8'h22) begin bad++; $display("FAIL areset_rerun_diff got=%h exp=22", b8.o_diff); end
  endtask

  task automatic test_random8();
    logic [31:0] ed;
    logic eb, eo;
    logic [7:0] a, b;
    int lat, bc;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      ref_sub(8, {24'd0, a}, {24'd0, b}, ed, eb, eo);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      start8(a, b);
      wait_done8(lat, bc);
      total++; if (lat !== 8) begin bad++; $display("FAIL rnd8_latency a=%h b=%h got=%0d exp=8", a, b, lat); end
      total++; if (b8.o_diff !== ed[7:0]) begin bad++; $display("FAIL rnd8_diff a=%h b=%h got=%h exp=%h", a, b, b8.o_diff, ed[7:0]); end
      total++; if (b8.o_borrow !== eb) begin bad++; $display("FAIL rnd8_borrow a=%h b=%h got=%b exp=%b", a, b, b8.o_borrow, eb); end
      total++; if (b8.o_ovf !== eo) begin bad++; $display("FAIL rnd8_ovf a=%h b=%h got=%b exp=%b", a, b, b8.o_ovf, eo); end
    end
  endtask

  task automatic test_random13();
    logic [31:0] ed;
    logic eb, eo;
    logic [12:0] a, b;
    int lat, acc;
    for (int n = 0; n < 1000; n++) begin
      a = 13'($urandom);
      b = 13'($urandom);
      // Corner operands mixed in: extremes of the signed and unsigned range.
      if (n < 4) begin
        a = (n[0]) ? 13'h1000 : 13'h0FFF;
        b = (n[1]) ? 13'h1FFF : 13'h0001;
      end
      ref_sub(13, {19'd0, a}, {19'd0, b}, ed, eb, eo);
      b13.i_start = 1'b1; b13.i_a = a; b13.i_b = b;
      tick();
      b13.i_start = 1'b0;
      acc = cyc;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
        if (b13.o_done) begin
          lat = cyc - acc;
          break;
        end
        tick();
      end
      total++; if (lat !== 13) begin bad++; $display("FAIL rnd13_latency a=%h b=%h got=%0d exp=13", a, b, lat); end
      total++; if (b13.o_diff !== ed[12:0]) begin bad++; $display("FAIL rnd13_diff a=%h b=%h got=%h exp=%h", a, b, b13.o_diff, ed[12:0]); end
      total++; if (b13.o_borrow !== eb) begin bad++; $display("FAIL rnd13_borrow a=%h b=%h got=%b exp=%b", a, b, b13.o_borrow, eb); end
      total++; if (b13.o_ovf !== eo) begin bad++; $display("FAIL rnd13_ovf a=%h b=%h got=%b exp=%b", a, b, b13.o_ovf, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_full_subtractor();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random8();
    test_random13();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned/two's-complement subtractor. It computes A - B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the ripple adder datapath. It trades latency for area, and exposes a start/busy/done handshake to the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
i_clk  input  1  rising-edge clock
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  request; sampled on rising edge of i_clk; accepted only in IDLE or DONE
i_a  input  WIDTH  minuend; captured on the accepting edge only
i_b  input  WIDTH  subtrahend; captured on the accepting edge only
o_busy  output  1  high while state is SHIFT
o_done  output  1  single-cycle pulse: result registers updated
o_diff  output  WIDTH  A - B modulo 2^WIDTH; held until the next completion
o_borrow  output  1  final borrow-out; 1 iff A < B unsigned
o_ovf  output  1  signed overflow of A - B (two's complement)

Behaviour:
- Reset (async, i_reset=1): state=IDLE; counter, borrow register, shift registers cleared; o_busy=0, o_done=0, o_diff=0, o_borrow=0, o_ovf=0. Applies immediately, including mid-operation; the aborted operation never produces o_done.
- States: IDLE, SHIFT, DONE.
- IDLE: if i_start=1, the same edge does the following, then goes to SHIFT:
  - load sh_a<=i_a, sh_b<=i_b
  - save a_msb<=i_a[WIDTH-1], b_msb<=i_b[WIDTH-1]
  - clear borrow register and bit counter
- SHIFT, each cycle:
  - full_subtractor(sh_a[0], sh_b[0], borrow) gives d, bout
  - sh_res <= {d, sh_res[WIDTH-1:1]}; sh_a, sh_b shift right by 1; borrow<=bout; counter+1
  - i_start is ignored; operands are not re-sampled
- Last bit: when counter==WIDTH-1, that edge goes to DONE and also loads:
  - o_diff <= {d, sh_res[WIDTH-1:1]}
  - o_borrow <= bout
  - o_ovf <= (a_msb != b_msb) && (d != a_msb)
- DONE (one cycle): o_done=1 (registered state decode). Next state is IDLE, or SHIFT with a new load if i_start=1 (back-to-back, no bubble).
- Latency: start accepted at edge E0; o_done is high in the cycle after edge E0+WIDTH, i.e. exactly WIDTH clocks after acceptance. Throughput: one result per WIDTH+1 cycles.
- o_diff, o_borrow and o_ovf change only on a completion edge or reset. They never show partial results during SHIFT.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- Arithmetic: o_diff equals (i_a - i_b) mod 2^WIDTH for all inputs. Borrow chain begins at 0 (no external borrow-in).
- o_busy and o_done are never high simultaneously.

Decomposition:
- Shared package subtraction_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- One sub-module full_subtractor (combinational):
  - inputs i_a, i_b, i_borrow; outputs o_diff, o_borrow
  - o_diff = i_a ^ i_b ^ i_borrow
  - o_borrow = (~i_a & i_b) | (~(i_a ^ i_b) & i_borrow)
  - instantiated once in the serial datapath
- Unit-test full_subtractor exhaustively (8 vectors) before integration.

Test Plan:
- WIDTH=8, A=0x5A, B=0x23, start pulse -> o_busy high 8 cycles; o_done exactly 8 clocks after accept; o_diff=0x37, o_borrow=0, o_ovf=0.
- A=0x10, B=0x20 -> o_diff=0xF0, o_borrow=1, o_ovf=0. Then A=0x00, B=0xFF -> o_diff=0x01, o_borrow=1, o_ovf=0.
- A=0x80, B=0x01 -> o_diff=0x7F, o_borrow=0, o_ovf=1. Then A=0x7F, B=0xFF -> o_diff=0x80, o_borrow=1, o_ovf=1.
- Start 0x5A-0x23, then pulse i_start with A=0xFF, B=0x00 during SHIFT cycle 3 -> ignored; result still 0x37. Start held high in the DONE cycle with A=0x09, B=0x04 -> next o_done 8 clocks later with o_diff=0x05.
- Start 0x33-0x11; assert i_reset asynchronously mid-cycle at SHIFT cycle 4 -> all outputs 0 immediately, no o_done. Release reset, run 0x33-0x11 -> o_diff=0x22.
- Randomised: 1000 random A/B pairs at WIDTH=8 and WIDTH=13 against a reference model -> o_diff, o_borrow and o_ovf all match; latency always WIDTH.
